// File: rtl/counter_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_datapath : saturating counter, limit alarm, BCD 7-segment display |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module counter_datapath #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add,
  input  logic             clr,
  input  logic             lim_load,
  input  logic [WIDTH-1:0] lim_in,
  output logic [WIDTH-1:0] count,
  output logic             al,
  output logic             ovf,
  output logic             bcd_valid,
  output logic [6:0]       seg_h,
  output logic [6:0]       seg_t,
  output logic [6:0]       seg_u
);

  // Four BCD nibbles so that WIDTH=10 values above 999 cannot corrupt the hundreds digit.
  localparam int               c_SR_W      = WIDTH + 16;
  localparam logic [WIDTH-1:0] c_MAX       = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_LIMIT_RST = WIDTH'(LIMIT);
  localparam logic [3:0]       c_BIT_LAST  = 4'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [WIDTH-1:0]  r_count;
  logic [WIDTH-1:0]  r_limit;
  logic              r_ovf;
  state_t            r_state;
  logic [c_SR_W-1:0] r_shift;
  logic [3:0]        r_bitcnt;
  logic [WIDTH-1:0]  r_last;
  logic [3:0]        r_dig_h;
  logic [3:0]        r_dig_t;
  logic [3:0]        r_dig_u;

  logic [c_SR_W-1:0] w_adjusted;
  logic [c_SR_W-1:0] w_shifted;
  logic [c_SR_W-1:0] w_capture;
  logic              w_changed;

  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Counter, overflow and limit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_limit <= c_LIMIT_RST;
    end else begin
      if (clr) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (add) begin
        if (r_count != c_MAX) begin
          r_count <= r_count + c_ONE;
        end else begin
          r_ovf <= 1'b1;
        end
      end
      if (lim_load) begin
        r_limit <= lim_in;
      end
    end
  end

  always_comb begin
    w_adjusted = r_shift;
    for (int i = 0; i < 4; i++) begin
      if (r_shift[WIDTH+4*i +: 4] >= 4'd5) begin
        w_adjusted[WIDTH+4*i +: 4] = r_shift[WIDTH+4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_shifted = w_adjusted << 1;
  assign w_capture = {16'h0000, r_count};
  assign w_changed = (r_count != r_last);

  // Shift-and-add-3 converter; DONE chains straight into a new conversion if count moved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= 4'd0;
      r_last   <= '0;
      r_dig_h  <= 4'd0;
      r_dig_t  <= 4'd0;
      r_dig_u  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_changed) begin
            r_shift  <= w_capture;
            r_last   <= r_count;
            r_bitcnt <= 4'd0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift  <= w_shifted;
          r_bitcnt <= r_bitcnt + 4'd1;
          if (r_bitcnt == c_BIT_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_dig_u <= r_shift[WIDTH +: 4];
          r_dig_t <= r_shift[WIDTH+4 +: 4];
          r_dig_h <= r_shift[WIDTH+8 +: 4];
          if (w_changed) begin
            r_shift  <= w_capture;
            r_last   <= r_count;
            r_bitcnt <= 4'd0;
            r_state  <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign count     = r_count;
  assign ovf       = r_ovf;
  assign al        = (r_count >= r_limit);
  assign bcd_valid = (r_state == S_IDLE) && !w_changed;
  assign seg_h     = f_seg7(r_dig_h);
  assign seg_t     = f_seg7(r_dig_t);
  assign seg_u     = f_seg7(r_dig_u);

endmodule
`default_nettype wire

// File: tb/tb_counter_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_counter_datapath : scoreboard bench for counter_datapath (WIDTH=8)      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_counter_datapath;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         add = 1'b0;
  logic         clr = 1'b0;
  logic         lim_load = 1'b0;
  logic [W-1:0] lim_in = '0;
  logic [W-1:0] count;
  logic         al;
  logic         ovf;
  logic         bcd_valid;
  logic [6:0]   seg_h;
  logic [6:0]   seg_t;
  logic [6:0]   seg_u;

  typedef struct {
    logic [W-1:0] cnt;
    logic [6:0]   h;
    logic [6:0]   t;
    logic [6:0]   u;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   glitch_win = 1'b0;

  counter_datapath #(.WIDTH(W), .LIMIT(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .add       (add),
    .clr       (clr),
    .lim_load  (lim_load),
    .lim_in    (lim_in),
    .count     (count),
    .al        (al),
    .ovf       (ovf),
    .bcd_valid (bcd_valid),
    .seg_h     (seg_h),
    .seg_t     (seg_t),
    .seg_u     (seg_u)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_code(input logic [6:0] s);
    case (s)
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [W-1:0] c, input logic [6:0] h, input logic [6:0] t,
                      input logic [6:0] u);
    exp_t e;
    e.cnt = c;
    e.h   = h;
    e.t   = t;
    e.u   = u;
    q.push_back(e);
  endtask

  task automatic add_pulse();
    @(posedge clk);
    #1 add = 1'b1;
    @(posedge clk);
    #1 add = 1'b0;
  endtask

  task automatic hold_add(input int n);
    @(posedge clk);
    #1 add = 1'b1;
    repeat (n) @(posedge clk);
    #1 add = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: bcd_valid never rose, %0d display results outstanding", nm, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every rising bcd_valid retires one expected display result.
  initial begin : mon
    logic prev_v;
    exp_t e;
    prev_v = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (glitch_win) begin
          chk("busy_bcd_valid", bcd_valid, 0);
          chk("busy_seg_t_code", is_code(seg_t), 1);
          chk("busy_seg_u_code", is_code(seg_u), 1);
        end
        if (bcd_valid && !prev_v) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got count=%0d, expected no bcd_valid rise", count);
          end else begin
            e = q.pop_front();
            chk("disp_count", count, e.cnt);
            chk("seg_h", seg_h, e.h);
            chk("seg_t", seg_t, e.t);
            chk("seg_u", seg_u, e.u);
          end
        end
      end
      prev_v = bcd_valid;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_al", al, 0);
    chk("rst_bcd_valid", bcd_valid, 1);
    chk("rst_seg_h", seg_h, 7'h40);
    chk("rst_seg_t", seg_t, 7'h40);
    chk("rst_seg_u", seg_u, 7'h40);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("release_count", count, 0);

    // Ten pulses, three cycles apart; alarm only once count reaches the limit of 10
    for (int k = 1; k <= 10; k++) begin
      add_pulse();
      if (k == 10) push(8'd10, 7'h40, 7'h79, 7'h40);
      @(negedge clk);
      chk("pulse_count", count, k);
      chk("pulse_al", al, (k >= 10));
      if (k < 10) @(posedge clk);
    end
    drain("drain_10");

    // 36 settled, then single step to 37 with latency check
    hold_add(26);
    push(8'd36, 7'h40, 7'h30, 7'h02);
    drain("drain_36");
    add_pulse();
    push(8'd37, 7'h40, 7'h30, 7'h78);
    @(negedge clk);
    chk("lat_cycle1_low", bcd_valid, 0);
    repeat (9) @(negedge clk);
    chk("lat_cycle10_low", bcd_valid, 0);
    @(negedge clk);
    chk("lat_cycle11_high", bcd_valid, 1);
    drain("drain_37");

    // Saturation: 260 cycles of add from 37
    @(posedge clk);
    #1 add = 1'b1;
    repeat (218) @(posedge clk);
    push(8'd255, 7'h24, 7'h12, 7'h12);
    @(negedge clk);
    chk("sat_count", count, 255);
    chk("sat_ovf_not_yet", ovf, 0);
    @(negedge clk);
    chk("sat_count_hold", count, 255);
    chk("sat_ovf_set", ovf, 1);
    repeat (41) @(posedge clk);
    #1 add = 1'b0;
    @(negedge clk);
    chk("sat_no_wrap", count, 255);
    chk("sat_ovf_sticky", ovf, 1);
    drain("drain_255");

    // Clear, count to 5, then clr+add together
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    push(8'd0, 7'h40, 7'h40, 7'h40);
    @(negedge clk);
    chk("clr_count", count, 0);
    chk("clr_ovf", ovf, 0);
    drain("drain_clr");
    hold_add(5);
    chk("five_count", count, 5);
    clr = 1'b1;
    add = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    add = 1'b0;
    push(8'd0, 7'h40, 7'h40, 7'h40);
    @(negedge clk);
    chk("clradd_count", count, 0);
    chk("clradd_ovf", ovf, 0);
    chk("clradd_al", al, 0);
    @(posedge clk);
    #1 lim_load = 1'b1;
    lim_in = '0;
    @(posedge clk);
    #1 lim_load = 1'b0;
    @(negedge clk);
    chk("lim0_al", al, 1);
    chk("lim0_count", count, 0);
    drain("drain_clradd");

    // Pulses two cycles apart, faster than a conversion
    add_pulse();
    glitch_win = 1'b1;
    for (int k = 2; k <= 7; k++) add_pulse();
    push(8'd7, 7'h40, 7'h40, 7'h78);
    repeat (3) @(posedge clk);
    glitch_win = 1'b0;
    chk("fast_count", count, 7);
    drain("drain_fast");

    // Asynchronous reset in the middle of a conversion
    add_pulse();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_ovf", ovf, 0);
    chk("async_al", al, 0);
    chk("async_bcd_valid", bcd_valid, 1);
    chk("async_seg_h", seg_h, 7'h40);
    chk("async_seg_t", seg_t, 7'h40);
    chk("async_seg_u", seg_u, 7'h40);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_count", count, 0);
    add_pulse();
    push(8'd1, 7'h40, 7'h40, 7'h79);
    @(negedge clk);
    chk("post_rst_first_add", count, 1);
    drain("drain_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_datapath.md
COUNTER_DATAPATH -- requirements
Module: counter_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the count and limit width in bits (legal range 4..10).
REQ-002 The block SHALL have parameter LIMIT, default 10, meaning the reset value of the limit register.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port add, input, 1 bit, the increment request: one increment per cycle while high.
REQ-006 The block SHALL have port clr, input, 1 bit, the synchronous clear of count and overflow.
REQ-007 The block SHALL have port lim_load, input, 1 bit, the load strobe for the limit register.
REQ-008 The block SHALL have port lim_in, input, WIDTH bits, the new limit value.
REQ-009 The block SHALL have port count, output, WIDTH bits, the current count register value.
REQ-010 The block SHALL have port al, output, 1 bit, the alarm: high when count >= limit.
REQ-011 The block SHALL have port ovf, output, 1 bit, the sticky saturation flag.
REQ-012 The block SHALL have port bcd_valid, output, 1 bit, high when the display digits match the current count.
REQ-013 The block SHALL have ports seg_h, seg_t and seg_u, output, 7 bits each, the active-low segment drives for hundreds, tens and units; bit0 = a ... bit6 = g.

Function
REQ-014 On each rising clk edge, the block SHALL apply clr first: count <= 0 and ovf <= 0; add is ignored in that cycle.
REQ-015 Otherwise, add with count < 2^WIDTH-1 SHALL set count <= count+1.
REQ-016 Otherwise, add with count = 2^WIDTH-1 SHALL hold count and set ovf <= 1, with no wrap-around.
REQ-017 ovf SHALL remain set until clr or reset.
REQ-018 lim_load SHALL set the limit register <= lim_in at the clock edge; the load is independent of clr and add and may occur in the same cycle.
REQ-019 al SHALL be combinational from the registered count and the registered limit, with zero extra latency, so al is valid in the cycle after the add edge.
REQ-020 When the limit is 0, al SHALL be 1 continuously.
REQ-021 The converter SHALL be an iterative binary-to-BCD converter (shift-and-add-3) with states IDLE, SHIFT and DONE.
REQ-022 In IDLE, the converter SHALL capture count into a shift register and enter SHIFT whenever count differs from the last converted value.
REQ-023 SHIFT SHALL last exactly WIDTH cycles, one bit per cycle, with add-3 applied to any BCD nibble >= 5 before each shift.
REQ-024 DONE SHALL last 1 cycle, latch the hundreds, tens and units digits into output registers, and return to IDLE.
REQ-025 bcd_valid SHALL go low in the cycle after count changes and go high in the cycle after DONE.
REQ-026 Total latency from a count change to bcd_valid=1 SHALL be WIDTH+2 cycles.
REQ-027 If count changes while in SHIFT or DONE, the converter SHALL finish the current conversion, latch its result, then immediately start again; bcd_valid SHALL stay low throughout.
REQ-028 The segment decoders SHALL be combinational from the latched digit registers.
REQ-029 Digit codes 0-9 SHALL map to standard patterns; codes 10-15 SHALL drive all segments off (7'h7F).
REQ-030 During a conversion the segment outputs SHALL hold the last latched digits, with no glitching to intermediate values.
REQ-031 seg_h SHALL display the hundreds digit; for WIDTH < 7, seg_h SHALL always show 0.

Reset
REQ-032 While rst_n=0, the block SHALL immediately and asynchronously force count=0, limit=LIMIT, ovf=0 and converter=IDLE.
REQ-033 While rst_n=0, the digit registers SHALL be 0, bcd_valid=1, and seg_h, seg_t and seg_u SHALL each be 7'h40 (digit 0).
REQ-034 al SHALL reflect count=0 versus limit=LIMIT (al=0 for the default LIMIT).
REQ-035 Reset asserted mid-conversion SHALL abort the conversion; no partial digits SHALL be latched.
REQ-036 Release of rst_n SHALL take effect at the next rising clk edge, with no spurious increment, load or conversion.

Verification
REQ-037 The bench SHALL cover: reset, then 10 single-cycle add pulses spaced 3 cycles apart -> count=10, al rises the cycle after the 10th add edge, al=0 before it.
REQ-038 The bench SHALL cover: count=37, then settle -> bcd_valid high after 10 cycles (WIDTH=8); seg_h=7'h40, seg_t=7'h30, seg_u=7'h78.
REQ-039 The bench SHALL cover: add held high for 260 cycles -> count saturates at 255, ovf=1 at the edge after count reaches 255, no wrap to 0.
REQ-040 The bench SHALL cover: clr and add high in the same cycle at count=5 -> count=0, ovf=0; then lim_load with lim_in=0 -> al=1 with count=0.
REQ-041 The bench SHALL cover: add pulses 2 cycles apart (faster than the conversion) -> bcd_valid stays low, segments never show a non-BCD pattern, the final digits equal the final count.
REQ-042 The bench SHALL cover: rst_n asserted asynchronously between clock edges, mid-SHIFT -> outputs take reset values before the next edge; after release, the first add gives count=1.
